// File: rtl/memory_cycle.sv
// MEM stage of a five-stage RISC-V pipeline: byte-lane data memory, load extension,
// misalignment detection and the MEM/WB pipeline register.
module memory_cycle #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [2:0]      LoadTypeM,
    input  logic [2:0]      StoreTypeM,
    output logic [XLEN-1:0] ALU_ResultMEM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] ResultW,
    output logic            MisalignW
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = XLEN / 8;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    localparam logic [2:0] ST_B = 3'b000;
    localparam logic [2:0] ST_H = 3'b001;
    localparam logic [2:0] ST_W = 3'b010;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    logic [XLEN-1:0] mem [DEPTH];

    logic [AW-1:0]    word_idx;
    logic [1:0]       byte_off;
    logic [XLEN-1:0]  rd_word;
    logic             load_mis;
    logic             store_mis;
    logic             load_sel;
    logic [XLEN-1:0]  load_data;
    logic [LANES-1:0] wr_mask;
    logic [XLEN-1:0]  wr_lanes;

    function automatic logic load_misaligned(input logic [2:0] t, input logic [1:0] off);
        case (t)
            LD_H, LD_HU: return off[0];
            LD_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic store_misaligned(input logic [2:0] t, input logic [1:0] off);
        case (t)
            ST_H:    return off[0];
            ST_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] t, input logic [1:0] off,
                                                    input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (t)
            LD_B:    return {{(XLEN-8){b[7]}}, b};
            LD_H:    return {{(XLEN-16){h[15]}}, h};
            LD_BU:   return {{(XLEN-8){1'b0}}, b};
            LD_HU:   return {{(XLEN-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    // Unknown store encodings write no lanes at all.
    function automatic logic [LANES-1:0] store_mask(input logic [2:0] t, input logic [1:0] off);
        case (t)
            ST_B:    return {{(LANES-1){1'b0}}, 1'b1} << off;
            ST_H:    return {{(LANES-2){1'b0}}, 2'b11} << {off[1], 1'b0};
            ST_W:    return {LANES{1'b1}};
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] t, input logic [XLEN-1:0] d);
        case (t)
            ST_B:    return {LANES{d[7:0]}};
            ST_H:    return {(LANES/2){d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign word_idx      = ALU_ResultM[AW+1:2];
    assign byte_off      = ALU_ResultM[1:0];
    assign rd_word       = mem[word_idx];
    assign ALU_ResultMEM = ALU_ResultM;

    assign load_sel  = (ResultSrcM == SRC_LOAD);
    assign load_mis  = load_misaligned(LoadTypeM, byte_off);
    assign store_mis = store_misaligned(StoreTypeM, byte_off);

    always_comb begin
        load_data = load_extend(LoadTypeM, byte_off, rd_word);
        if (load_sel && load_mis)
            load_data = '0;
    end

    always_comb begin
        wr_mask  = store_mask(StoreTypeM, byte_off);
        wr_lanes = store_lanes(StoreTypeM, WriteDataM);
        if (!MemWriteM || store_mis)
            wr_mask = '0;
    end

    // The array is never cleared; reset only keeps a store from landing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else begin
            for (int b = 0; b < LANES; b++) begin
                if (wr_mask[b])
                    mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    // MEM/WB boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RD_W        <= 5'd0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            MisalignW   <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= load_data;
            MisalignW   <= (store_mis && MemWriteM) || (load_mis && load_sel);
        end
    end

    always_comb begin
        case (ResultSrcW)
            SRC_ALU:  ResultW = ALU_ResultW;
            SRC_LOAD: ResultW = ReadDataW;
            SRC_PC4:  ResultW = PCPlus4W;
            default:  ResultW = '0;
        endcase
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: byte-addressed reference memory model checked every cycle,
// plus directed load/store vectors with hand-computed results.
module tb_memory_cycle;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int BYTES = DEPTH * 4;

    logic            clk;
    logic            rst;
    logic            RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] PCPlus4M, ALU_ResultM, WriteDataM;
    logic [2:0]      LoadTypeM, StoreTypeM;
    logic [XLEN-1:0] ALU_ResultMEM;
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic [4:0]      RD_W;
    logic [XLEN-1:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;
    logic            MisalignW;

    memory_cycle #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM),
        .WriteDataM(WriteDataM), .LoadTypeM(LoadTypeM), .StoreTypeM(StoreTypeM),
        .ALU_ResultMEM(ALU_ResultMEM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RD_W(RD_W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
        .ReadDataW(ReadDataW), .ResultW(ResultW), .MisalignW(MisalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a flat little-endian byte array with sizes and offsets.
    logic [7:0]  bmem [BYTES];
    logic        e_rw;
    logic [1:0]  e_src;
    logic [4:0]  e_rd;
    logic [31:0] e_pc4, e_alu, e_rdata;
    logic        e_mis;
    int          m_a, m_lsz, m_ssz;
    bit          m_lsgn, m_lmis, m_smis;
    logic [31:0] m_val;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_rw = 0; e_src = 0; e_rd = 0; e_pc4 = 0; e_alu = 0; e_rdata = 0; e_mis = 0;
        end else begin
            m_a = int'(ALU_ResultM % BYTES);
            case (LoadTypeM)
                3'b000:  begin m_lsz = 1; m_lsgn = 1; end
                3'b001:  begin m_lsz = 2; m_lsgn = 1; end
                3'b100:  begin m_lsz = 1; m_lsgn = 0; end
                3'b101:  begin m_lsz = 2; m_lsgn = 0; end
                default: begin m_lsz = 4; m_lsgn = 0; end
            endcase
            m_lmis = (LoadTypeM == 3'b001 || LoadTypeM == 3'b101 || LoadTypeM == 3'b010)
                     && (m_a % m_lsz != 0);
            if (m_lmis || m_lsz == 4) m_a = m_a - (m_a % 4);
            m_val = 0;
            for (int i = 0; i < m_lsz; i++) m_val[8*i +: 8] = bmem[m_a + i];
            if (m_lsgn && m_val[8*m_lsz-1])
                for (int i = 8*m_lsz; i < 32; i++) m_val[i] = 1'b1;
            if (m_lmis && ResultSrcM == 2'b01) m_val = 0;

            m_a = int'(ALU_ResultM % BYTES);
            m_ssz = (StoreTypeM == 3'b000) ? 1 : (StoreTypeM == 3'b001) ? 2 :
                    (StoreTypeM == 3'b010) ? 4 : 0;
            m_smis = (m_ssz > 1) && (m_a % m_ssz != 0);
            if (MemWriteM && !m_smis && m_ssz > 0)
                for (int i = 0; i < m_ssz; i++) bmem[m_a + i] = WriteDataM[8*i +: 8];

            e_rw = RegWriteM; e_src = ResultSrcM; e_rd = RD_M; e_pc4 = PCPlus4M;
            e_alu = ALU_ResultM; e_rdata = m_val;
            e_mis = (m_smis && MemWriteM) || (m_lmis && ResultSrcM == 2'b01);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_regwrite", 32'(RegWriteW), 32'(e_rw));
            check("m_src", 32'(ResultSrcW), 32'(e_src));
            check("m_rd", 32'(RD_W), 32'(e_rd));
            check("m_pc4", PCPlus4W, e_pc4);
            check("m_alu", ALU_ResultW, e_alu);
            check("m_rdata", ReadDataW, e_rdata);
            check("m_misalign", 32'(MisalignW), 32'(e_mis));
            check("m_result", ResultW, (e_src == 2'b00) ? e_alu : (e_src == 2'b01) ? e_rdata :
                                       (e_src == 2'b10) ? e_pc4 : 32'h0);
            check("m_fwd", ALU_ResultMEM, ALU_ResultM);
        end
    end

    task automatic drive(input logic rw, input logic mw, input logic [1:0] src,
                         input logic [2:0] lt, input logic [2:0] st, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = src; LoadTypeM = lt; StoreTypeM = st;
        ALU_ResultM = addr; WriteDataM = wd; PCPlus4M = pc4; RD_M = rd;
    endtask

    task automatic step(input logic rw, input logic mw, input logic [1:0] src,
                        input logic [2:0] lt, input logic [2:0] st, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd);
        drive(rw, mw, src, lt, st, addr, wd, pc4, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [2:0] st, input logic [31:0] addr, input logic [31:0] wd);
        step(0, 1, 2'b00, 3'b010, st, addr, wd, 32'h100, 5'd0);
    endtask

    task automatic load(input logic [2:0] lt, input logic [31:0] addr, input logic [4:0] rd);
        step(1, 0, 2'b01, lt, 3'b010, addr, 32'h0, 32'h200, rd);
    endtask

    initial begin
        for (int i = 0; i < BYTES; i++) bmem[i] = 8'h00;
        rst = 1'b0;
        drive(1, 1, 2'b10, 3'b010, 3'b010, 32'h10, 32'hFFFF_FFFF, 32'h44, 5'd7);
        @(posedge clk);
        #1;
        check("rst_regwrite", 32'(RegWriteW), 32'h0);
        check("rst_result", ResultW, 32'h0);
        check("rst_misalign", 32'(MisalignW), 32'h0);
        check("rst_rd", 32'(RD_W), 32'h0);
        rst = 1'b1;
        chk_en = 1'b1;

        store(3'b010, 32'h10, 32'hDEAD_BEEF);
        load(3'b010, 32'h10, 5'd1);
        check("lw_deadbeef", ResultW, 32'hDEAD_BEEF);
        check("lw_rd", 32'(RD_W), 32'd1);

        store(3'b000, 32'h11, 32'hFFFF_FF7F);
        load(3'b000, 32'h11, 5'd2);  check("lb_11", ResultW, 32'h0000_007F);
        load(3'b000, 32'h13, 5'd2);  check("lb_13", ResultW, 32'hFFFF_FFDE);
        load(3'b100, 32'h13, 5'd2);  check("lbu_13", ResultW, 32'h0000_00DE);
        load(3'b010, 32'h10, 5'd2);  check("lw_after_sb", ResultW, 32'hDEAD_7FEF);
        load(3'b001, 32'h12, 5'd3);  check("lh_12", ResultW, 32'hFFFF_DEAD);
        load(3'b101, 32'h12, 5'd3);  check("lhu_12", ResultW, 32'h0000_DEAD);
        load(3'b001, 32'h10, 5'd3);  check("lh_10", ResultW, 32'h0000_7FEF);

        store(3'b001, 32'h12, 32'hABCD_1234);
        load(3'b010, 32'h10, 5'd4);  check("lw_after_sh", ResultW, 32'h1234_7FEF);

        store(3'b010, 32'h12, 32'h5555_5555);
        check("sw_mis_flag", 32'(MisalignW), 32'h1);
        step(0, 0, 2'b00, 3'b010, 3'b010, 32'h0, 32'h0, 32'h0, 5'd0);
        check("mis_pulse_end", 32'(MisalignW), 32'h0);
        load(3'b010, 32'h10, 5'd5);  check("sw_mis_nowrite", ResultW, 32'h1234_7FEF);
        load(3'b010, 32'h13, 5'd5);
        check("lw_mis_zero", ResultW, 32'h0);
        check("lw_mis_flag", 32'(MisalignW), 32'h1);
        load(3'b001, 32'h11, 5'd5);  check("lh_mis_zero", ResultW, 32'h0);
        store(3'b001, 32'h13, 32'h0000_9999);
        check("sh_mis_flag", 32'(MisalignW), 32'h1);

        for (int i = 0; i < 4; i++) store(3'b000, 32'h20 + i, 32'h11 * (i + 1));
        load(3'b010, 32'h20, 5'd6);  check("sb_lanes", ResultW, 32'h4433_2211);
        store(3'b001, 32'h20, 32'hFFFF_8001);
        load(3'b001, 32'h20, 5'd6);  check("lh_low_neg", ResultW, 32'hFFFF_8001);
        load(3'b010, 32'h20, 5'd6);  check("sh_low_lane", ResultW, 32'h4433_8001);

        store(3'b010, BYTES + 32'h10, 32'hA5A5_A5A5);
        load(3'b010, 32'h10, 5'd8);  check("wrap_lw", ResultW, 32'hA5A5_A5A5);

        step(1, 1, 2'b01, 3'b010, 3'b010, 32'h30, 32'h0BAD_F00D, 32'h300, 5'd9);
        check("st_and_ld_rd", 32'(RegWriteW), 32'h1);
        load(3'b010, 32'h30, 5'd9);  check("st_and_ld_data", ResultW, 32'h0BAD_F00D);
        step(1, 0, 2'b00, 3'b000, 3'b010, 32'h1234_5678, 32'h0, 32'h0, 5'd10);
        check("src_alu", ResultW, 32'h1234_5678);
        step(1, 0, 2'b11, 3'b000, 3'b010, 32'h1234_5678, 32'h0, 32'h888, 5'd10);
        check("src_reserved", ResultW, 32'h0);

        drive(0, 1, 2'b00, 3'b010, 3'b010, 32'h10, 32'h1111_1111, 32'h0, 5'd0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_alu", ALU_ResultW, 32'h0);
        check("async_rst_rw", 32'(RegWriteW), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1, 0, 2'b10, 3'b000, 3'b010, 32'h0, 32'h0, 32'h0000_0104, 5'd11);
        check("pc4_after_rst", ResultW, 32'h0000_0104);
        load(3'b010, 32'h10, 5'd12); check("rst_blocked_store", ResultW, 32'hA5A5_A5A5);

        step(0, 0, 2'b00, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter DEPTH, default 1024, data-memory words (power of two).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 RegWriteM  input  1  register-file write enable from EX/MEM.
REQ-006 MemWriteM  input  1  store enable.
REQ-007 ResultSrcM  input  2  writeback select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
REQ-008 RD_M  input  5  destination register.
REQ-009 PCPlus4M  input  XLEN  link value.
REQ-010 ALU_ResultM  input  XLEN  effective address / ALU result.
REQ-011 WriteDataM  input  XLEN  forwarded store data.
REQ-012 LoadTypeM  input  3  funct3 load encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-013 StoreTypeM  input  3  funct3 store encoding: 000 SB, 001 SH, 010 SW.
REQ-014 ALU_ResultMEM  output  XLEN  combinational copy of ALU_ResultM for EX forwarding.
REQ-015 RegWriteW, ResultSrcW[1:0], RD_W[4:0], PCPlus4W, ALU_ResultW, ReadDataW  output  MEM/WB register contents.
REQ-016 ResultW  output  XLEN  combinational writeback value.
REQ-017 MisalignW  output  1  registered misaligned-access flag.

Function
REQ-018 Memory array: DEPTH x XLEN; word index = ALU_ResultM[log2(DEPTH)+1:2]; upper address bits ignored (wrap modulo DEPTH words).
REQ-019 Read combinational from array; write on rising clk edge, byte-lane masked; same-cycle read returns pre-write data.
REQ-020 SB writes byte lane ALU_ResultM[1:0] with WriteDataM[7:0]; SH writes half lane ALU_ResultM[1] with WriteDataM[15:0]; SW writes all four lanes; other lanes unchanged.
REQ-021 Loads select byte/half by address bits; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; unlisted LoadTypeM codes yield full word.
REQ-022 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00; byte never misaligned.
REQ-023 Misaligned store: array write suppressed entirely.
REQ-024 Misaligned load (ResultSrcM=01): extended data forced to 0.
REQ-025 MisalignW registers (misaligned & MemWriteM) | (misaligned & ResultSrcM==01); one-cycle pulse per offending instruction.
REQ-026 MEM/WB register: every rising edge, W outputs take M-stage values; ReadDataW takes extended load data; latency exactly one cycle.
REQ-027 ResultW = ALU_ResultW (00), ReadDataW (01), PCPlus4W (10), 0 (11).
REQ-028 MemWriteM with RegWriteM both high: both honoured independently.
REQ-029 No stall/flush inputs; bubbles arrive as RegWriteM=0, MemWriteM=0.

Reset
REQ-030 On rst low: RegWriteW=0, ResultSrcW=00, RD_W=0, PCPlus4W=0, ALU_ResultW=0, ReadDataW=0, MisalignW=0, immediately (asynchronous).
REQ-031 Memory array contents not reset; stores blocked while rst low.
REQ-032 Reset asserted mid-store cycle: write does not occur; release resumes normal operation next edge.

Verification
REQ-033 SW 0xDEADBEEF @0x10, next cycle LW @0x10, ResultSrc=01 -> ResultW=0xDEADBEEF one cycle after load.
REQ-034 SB 0x7F @0x11 over 0xDEADBEEF, then LB @0x11 -> 0x0000007F; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; word now 0xDEAD7FEF.
REQ-035 LH @0x12 -> 0xFFFFDEAD; LHU @0x12 -> 0x0000DEAD; SH 0x1234 @0x12 -> word 0x1234xxxx, low half unchanged.
REQ-036 SW @0x12 -> memory unchanged, MisalignW=1 for one cycle; LW @0x13 -> ResultW=0, MisalignW=1.
REQ-037 Address wrap: SW 0xA5A5A5A5 @(DEPTH*4+0x10), LW @0x10 -> 0xA5A5A5A5.
REQ-038 Assert rst during SW cycle -> all W outputs 0 asynchronously, target word unchanged; ResultSrc=10 after release -> ResultW=PCPlus4W.
